// File: rtl/vram_pkg.sv
// Shared types and defaults for the video/main SRAM arbiter.
package vram_pkg;

    localparam int unsigned DefAddrWidth    = 17;
    localparam int unsigned DefDataWidth    = 8;
    localparam int unsigned DefAccessCycles = 2;
    localparam int unsigned CntWidth        = 4;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StHold} state_e;

    typedef enum logic [1:0] {OwnVideo, OwnCpu, OwnPi} owner_e;

    // One-hot requester mask: bit 0 video, bit 1 CPU, bit 2 Pi.
    function automatic logic [2:0] owner_mask(owner_e owner);
        return 3'b001 << owner;
    endfunction

endpackage

// File: rtl/vram_grant_sel.sv
// Combinational grant decision: fixed video priority, CPU/Pi round-robin.
module vram_grant_sel
    import vram_pkg::*;
(
    input  logic       video_req_i,
    input  logic       cpu_req_i,
    input  logic       pi_req_i,
    input  logic [2:0] excl_i,
    input  logic       last_cpu_i,
    output logic       grant_valid_o,
    output owner_e     owner_o
);

    logic video_ok;
    logic cpu_ok;
    logic pi_ok;

    always_comb begin
        video_ok      = video_req_i & ~excl_i[0];
        cpu_ok        = cpu_req_i & ~excl_i[1];
        pi_ok         = pi_req_i & ~excl_i[2];
        grant_valid_o = video_ok | cpu_ok | pi_ok;
        owner_o       = OwnVideo;
        if (video_ok) begin
            owner_o = OwnVideo;
        end else if (cpu_ok && pi_ok) begin
            // Tie goes to whichever of CPU/Pi did not win last time.
            owner_o = last_cpu_i ? OwnPi : OwnCpu;
        end else if (cpu_ok) begin
            owner_o = OwnCpu;
        end else if (pi_ok) begin
            owner_o = OwnPi;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Shares the video/main SRAM between video fetch, 6502 and Pi bridge using a
// fixed SETUP / ACCESS / HOLD cycle with registered strobes.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = DefAddrWidth,
    parameter int unsigned DATA_WIDTH    = DefDataWidth,
    parameter int unsigned ACCESS_CYCLES = DefAccessCycles
) (
    input  logic                  clk16,
    input  logic                  res_b,
    input  logic                  video_req,
    input  logic [ADDR_WIDTH-1:0] video_addr,
    output logic                  video_ack,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    input  logic                  pi_req,
    input  logic                  pi_we,
    input  logic [ADDR_WIDTH-1:0] pi_addr,
    input  logic [DATA_WIDTH-1:0] pi_wdata,
    output logic                  pi_ack,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_oe_b,
    output logic                  ram_we_b
);

    localparam logic [CntWidth-1:0] CntLoad = CntWidth'(ACCESS_CYCLES - 1);

    state_e                state_q;
    owner_e                owner_q;
    logic                  we_q;
    logic                  last_cpu_q;
    logic [CntWidth-1:0]   cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  oe_b_q;
    logic                  we_b_q;
    logic                  video_ack_q;
    logic                  cpu_ack_q;
    logic                  pi_ack_q;

    logic                  grant_valid;
    owner_e                grant_owner;
    logic [2:0]            excl;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_we;
    logic [DATA_WIDTH-1:0] sel_wdata;

    vram_grant_sel u_grant_sel (
        .video_req_i  (video_req),
        .cpu_req_i    (cpu_req),
        .pi_req_i     (pi_req),
        .excl_i       (excl),
        .last_cpu_i   (last_cpu_q),
        .grant_valid_o(grant_valid),
        .owner_o      (grant_owner)
    );

    always_comb begin
        // The requester being acked in HOLD must not be re-granted on the same edge.
        excl      = (state_q == StHold) ? owner_mask(owner_q) : 3'b000;
        sel_addr  = video_addr;
        sel_we    = 1'b0;
        sel_wdata = '0;
        case (grant_owner)
            OwnCpu: begin
                sel_addr  = cpu_addr;
                sel_we    = cpu_we;
                sel_wdata = cpu_wdata;
            end
            OwnPi: begin
                sel_addr  = pi_addr;
                sel_we    = pi_we;
                sel_wdata = pi_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk16 or negedge res_b) begin
        if (!res_b) begin
            state_q     <= StIdle;
            owner_q     <= OwnVideo;
            we_q        <= 1'b0;
            last_cpu_q  <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_data_q   <= '0;
            oe_b_q      <= 1'b1;
            we_b_q      <= 1'b1;
            video_ack_q <= 1'b0;
            cpu_ack_q   <= 1'b0;
            pi_ack_q    <= 1'b0;
        end else begin
            video_ack_q <= 1'b0;
            cpu_ack_q   <= 1'b0;
            pi_ack_q    <= 1'b0;
            unique case (state_q)
                StIdle, StHold: begin
                    if (state_q == StHold && owner_q != OwnVideo) begin
                        last_cpu_q <= (owner_q == OwnCpu);
                    end
                    if (grant_valid) begin
                        owner_q <= grant_owner;
                        addr_q  <= sel_addr;
                        we_q    <= sel_we;
                        wdata_q <= sel_wdata;
                        state_q <= StSetup;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StSetup: begin
                    state_q <= StAccess;
                    cnt_q   <= CntLoad;
                    oe_b_q  <= we_q;
                    we_b_q  <= ~we_q;
                end
                StAccess: begin
                    if (cnt_q == '0) begin
                        state_q     <= StHold;
                        oe_b_q      <= 1'b1;
                        we_b_q      <= 1'b1;
                        video_ack_q <= (owner_q == OwnVideo);
                        cpu_ack_q   <= (owner_q == OwnCpu);
                        pi_ack_q    <= (owner_q == OwnPi);
                        if (!we_q) begin
                            rd_data_q <= ram_din;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign video_ack = video_ack_q;
    assign cpu_ack   = cpu_ack_q;
    assign pi_ack    = pi_ack_q;
    assign rd_data   = rd_data_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_oe_b  = oe_b_q;
    assign ram_we_b  = we_b_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: stimulus queues expected acks, a
// negedge monitor checks strobes, data, owner and ack timing.
module tb_vram_arbiter;

    localparam int AW  = 17;
    localparam int DW  = 8;
    localparam int ACC = 2;

    logic          clk16 = 1'b0;
    logic          res_b;
    logic          video_req;
    logic [AW-1:0] video_addr;
    logic          video_ack;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic          pi_req;
    logic          pi_we;
    logic [AW-1:0] pi_addr;
    logic [DW-1:0] pi_wdata;
    logic          pi_ack;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_din;
    logic          ram_oe_b;
    logic          ram_we_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int            owner;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            at;
    } exp_t;

    exp_t sb_q[$];

    int            st_len    = 0;
    bit            st_oe     = 1'b0;
    bit            st_we     = 1'b0;
    logic [AW-1:0] st_addr   = '0;
    logic [DW-1:0] st_wdata  = '0;
    int            n_strobes = 0;

    vram_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .ACCESS_CYCLES(ACC)
    ) dut (
        .clk16     (clk16),
        .res_b     (res_b),
        .video_req (video_req),
        .video_addr(video_addr),
        .video_ack (video_ack),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .pi_req    (pi_req),
        .pi_we     (pi_we),
        .pi_addr   (pi_addr),
        .pi_wdata  (pi_wdata),
        .pi_ack    (pi_ack),
        .rd_data   (rd_data),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_din   (ram_din),
        .ram_oe_b  (ram_oe_b),
        .ram_we_b  (ram_we_b)
    );

    always #5 clk16 = ~clk16;
    always @(posedge clk16) cyc <= cyc + 1;

    // SRAM model: read data is a fixed function of the address.
    assign ram_din = ram_addr[7:0] ^ 8'hA5;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push(input int owner, input bit we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                                 input int at);
        exp_t e;
        e.owner = owner;
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        e.rdata = rdata;
        e.at    = at;
        sb_q.push_back(e);
    endfunction

    always @(negedge clk16) begin : monitor
        exp_t e;
        int   own;
        int   n_ack;
        if (!res_b) begin
            st_len = 0;
            st_oe  = 1'b0;
            st_we  = 1'b0;
        end else begin
            if (!ram_oe_b || !ram_we_b) begin
                if (st_len == 0) begin
                    st_addr  = ram_addr;
                    st_wdata = ram_wdata;
                    st_oe    = 1'b0;
                    st_we    = 1'b0;
                    n_strobes++;
                end else begin
                    check("addr_stable_in_strobe", 32'(ram_addr), 32'(st_addr));
                end
                if (!ram_oe_b) st_oe = 1'b1;
                if (!ram_we_b) st_we = 1'b1;
                st_len++;
            end
            n_ack = 0;
            if (video_ack) n_ack++;
            if (cpu_ack) n_ack++;
            if (pi_ack) n_ack++;
            if (n_ack != 0) begin
                check("ack_onehot", 32'(n_ack), 32'd1);
                own = video_ack ? 0 : (cpu_ack ? 1 : 2);
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ack: owner %0d acked, none expected (cycle %0d)",
                             own, cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("ack_owner", 32'(own), 32'(e.owner));
                    check("ack_cycle", 32'(cyc), 32'(e.at));
                    check("strobe_len", 32'(st_len), 32'(ACC));
                    check("oe_strobe_seen", 32'(st_oe), 32'(!e.we));
                    check("we_strobe_seen", 32'(st_we), 32'(e.we));
                    check("strobe_addr", 32'(st_addr), 32'(e.addr));
                    check("hold_addr", 32'(ram_addr), 32'(e.addr));
                    if (e.we) check("strobe_wdata", 32'(st_wdata), 32'(e.wdata));
                    else check("rd_data", 32'(rd_data), 32'(e.rdata));
                end
                st_len = 0;
            end
        end
    end

    // Waits for n acks, dropping each requester's req on its ack.
    task automatic serve(input int n_acks, input int budget);
        int seen;
        seen = 0;
        for (int i = 0; i < budget && seen < n_acks; i++) begin
            @(negedge clk16);
            if (video_ack) begin video_req = 1'b0; seen++; end
            if (cpu_ack) begin cpu_req = 1'b0; seen++; end
            if (pi_ack) begin pi_req = 1'b0; seen++; end
        end
        if (seen < n_acks) begin
            n_checks++;
            n_fail++;
            $display("FAIL serve_timeout: got %0d acks, expected %0d", seen, n_acks);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_oe_b"}, 32'(ram_oe_b), 32'd1);
        check({tag, "_we_b"}, 32'(ram_we_b), 32'd1);
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        check({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
        check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        check({tag, "_acks"}, 32'({video_ack, cpu_ack, pi_ack}), 32'd0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n0;
        int ns;
        res_b      = 1'b0;
        video_req  = 1'b0;
        video_addr = '0;
        cpu_req    = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        pi_req     = 1'b0;
        pi_we      = 1'b0;
        pi_addr    = '0;
        pi_wdata   = '0;
        repeat (3) @(negedge clk16);
        check_reset_outputs("por");
        res_b = 1'b1;
        repeat (3) @(negedge clk16);
        check("idle_no_strobe", 32'(n_strobes), 32'd0);

        // Single CPU read.
        n0       = cyc;
        cpu_addr = 17'h08000;
        cpu_we   = 1'b0;
        cpu_req  = 1'b1;
        push(1, 1'b0, 17'h08000, 8'h00, 8'hA5, n0 + 4);
        serve(1, 12);
        repeat (2) @(negedge clk16);

        // Pi write to the top address.
        n0       = cyc;
        pi_addr  = 17'h1FFFF;
        pi_wdata = 8'h3C;
        pi_we    = 1'b1;
        pi_req   = 1'b1;
        push(2, 1'b1, 17'h1FFFF, 8'h3C, 8'h00, n0 + 4);
        @(negedge clk16);
        check("pi_setup_addr", 32'(ram_addr), 32'h1FFFF);
        check("pi_setup_strobes", 32'({ram_oe_b, ram_we_b}), 32'b11);
        serve(1, 12);
        repeat (2) @(negedge clk16);

        // All three at once: video, CPU, Pi back-to-back.
        n0         = cyc;
        video_addr = 17'h00123;
        cpu_addr   = 17'h04455;
        cpu_we     = 1'b0;
        pi_addr    = 17'h1ABCD;
        pi_we      = 1'b0;
        video_req  = 1'b1;
        cpu_req    = 1'b1;
        pi_req     = 1'b1;
        push(0, 1'b0, 17'h00123, 8'h00, 8'h86, n0 + 4);
        push(1, 1'b0, 17'h04455, 8'h00, 8'hF0, n0 + 8);
        push(2, 1'b0, 17'h1ABCD, 8'h00, 8'h68, n0 + 12);
        serve(3, 24);
        repeat (2) @(negedge clk16);

        // CPU and Pi re-request continuously; video cuts in once.
        n0         = cyc;
        cpu_addr   = 17'h00010;
        cpu_we     = 1'b0;
        pi_addr    = 17'h00020;
        pi_wdata   = 8'h77;
        pi_we      = 1'b1;
        video_addr = 17'h000FF;
        cpu_req    = 1'b1;
        pi_req     = 1'b1;
        push(1, 1'b0, 17'h00010, 8'h00, 8'hB5, n0 + 4);
        push(2, 1'b1, 17'h00020, 8'h77, 8'h00, n0 + 8);
        push(1, 1'b0, 17'h00010, 8'h00, 8'hB5, n0 + 12);
        push(2, 1'b1, 17'h00020, 8'h77, 8'h00, n0 + 16);
        push(0, 1'b0, 17'h000FF, 8'h00, 8'h5A, n0 + 20);
        push(1, 1'b0, 17'h00010, 8'h00, 8'hB5, n0 + 24);
        push(2, 1'b1, 17'h00020, 8'h77, 8'h00, n0 + 28);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk16);
            if (cyc - n0 == 14) video_req = 1'b1;
            if (video_ack) video_req = 1'b0;
            if (cyc - n0 == 28) begin
                cpu_req = 1'b0;
                pi_req  = 1'b0;
            end
        end
        repeat (2) @(negedge clk16);

        // Reset during the ACCESS phase of a CPU write.
        n0        = cyc;
        cpu_addr  = 17'h00AAA;
        cpu_wdata = 8'h99;
        cpu_we    = 1'b1;
        cpu_req   = 1'b1;
        repeat (2) @(negedge clk16);
        check("mid_write_we_low", 32'(ram_we_b), 32'd0);
        #1 res_b = 1'b0;
        #1 check_reset_outputs("async");
        cpu_we   = 1'b0;
        cpu_addr = 17'h00033;
        pi_we    = 1'b0;
        pi_addr  = 17'h00044;
        pi_req   = 1'b1;
        repeat (2) @(negedge clk16);
        n0    = cyc;
        res_b = 1'b1;
        push(1, 1'b0, 17'h00033, 8'h00, 8'h96, n0 + 4);
        push(2, 1'b0, 17'h00044, 8'h00, 8'hE1, n0 + 8);
        serve(2, 20);
        repeat (2) @(negedge clk16);

        // Requester drops req during SETUP: exactly one cycle, one ack.
        n0      = cyc;
        ns      = n_strobes;
        pi_addr = 17'h00055;
        pi_we   = 1'b0;
        pi_req  = 1'b1;
        push(2, 1'b0, 17'h00055, 8'h00, 8'hF0, n0 + 4);
        @(negedge clk16);
        pi_req = 1'b0;
        repeat (10) @(negedge clk16);
        check("drop_single_cycle", 32'(n_strobes - ns), 32'd1);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
